calc_entry_ctrl: RTL and testbench
==================================

# calc_entry_ctrl

Sequencing controller between the 4x4 keypad scanner and the calculator ALU. It consumes decoded key codes, builds a source operand, an operator and a destination operand, then issues one ALU operation with a start/done handshake. It reports completion with `OUT_finish`, or `OUT_error` if the ALU does not respond in time. A watchdog bounds every issued operation.

## Interface
- `MAX_DIGITS`, default 4: decimal digits accepted per operand; extra digits are ignored.
- `TIMEOUT`, default 1024: cycles allowed from `OUT_start` to `IN_alu_done` before the operation is aborted.
- `IN_clk` input 1: single clock for the block.
- `IN_rst_n` input 1: reset, asynchronous and active-low.
- `IN_key_valid` input 1: one-cycle pulse; `IN_key_code` is valid in that cycle.
- `IN_key_code` input 4: key code. 0-9 are digits, A=add, B=sub, C=and, D=or, E=cmp, F=equals.
- `IN_alu_done` input 1: ALU completion pulse.
- `OUT_key_ready` output 1: high in entry states, where keys are consumed.
- `OUT_SRCH`, `OUT_SRCL` output 8 each: high and low bytes of the 16-bit source operand.
- `OUT_DSTH`, `OUT_DSTL` output 8 each: high and low bytes of the 16-bit destination operand.
- `OUT_ALU_OP` output 8: operation code. 0x01 add, 0x02 sub, 0x04 and, 0x08 or, 0x10 cmp, 0x00 none.
- `OUT_start` output 1: one-cycle issue pulse.
- `OUT_finish` output 1: one-cycle pulse on successful completion.
- `OUT_error` output 1: one-cycle pulse on watchdog abort.

## Operation
States are ENTER_A, ENTER_B, ISSUE, WAIT and DONE. Reset enters ENTER_A.
- **ENTER_A**
  - Digit d: if the digit count is below `MAX_DIGITS`, `acc_a <= acc_a*10 + d` and the count increments; otherwise the key is ignored.
  - Operator key (A-E): if at least one digit has been entered, latch `OUT_ALU_OP` and go to ENTER_B. Otherwise ignore it.
  - F: ignored.
- **ENTER_B**
  - Digit d: accumulates into `acc_b` under the same digit limit.
  - Operator key: if no B digit has been entered yet, it replaces `OUT_ALU_OP`; after a B digit it is ignored.
  - F: if at least one B digit has been entered, go to ISSUE; otherwise ignore it.
- **ISSUE**: lasts one cycle. Drive `OUT_start`=1, load the watchdog with `TIMEOUT-1`, go to WAIT.
- **WAIT**
  - `IN_alu_done` → DONE with `OUT_finish` pulsed.
  - Watchdog reaches 0 with no done → pulse `OUT_error`, clear operands, return to ENTER_A.
  - Done and expiry in the same cycle: done wins.
- **DONE**: lasts one cycle. Clear `acc_a`, `acc_b`, digit counts and `OUT_ALU_OP`, then go to ENTER_A.

Data rules:
- Key codes outside the rules above are ignored.
- Operands are unsigned binary, 16 bits wide. With `MAX_DIGITS`=4 the maximum is 9999 = 0x270F, so no overflow is possible.
- `OUT_SRCH/SRCL` = `acc_a[15:8]/[7:0]` and `OUT_DSTH/DSTL` = `acc_b[15:8]/[7:0]`, both registered.
- The operand outputs and `OUT_ALU_OP` stay stable from ISSUE until leaving WAIT.

Boundary rules:
- Keys arriving in ISSUE, WAIT or DONE are dropped; there is no queuing.
- `IN_alu_done` outside WAIT is ignored.
- Reset asserted mid-operation immediately forces ENTER_A with every output at its reset value.

## Timing
- **Reset values**: every output is 0 except `OUT_key_ready`, which is 1 (ENTER_A).
- **Key registration**: a key pulsed in cycle N updates the accumulator or state at edge N+1, visible in cycle N+1.
- **Issue**: F accepted at edge N puts ISSUE in cycle N+1 with `OUT_start`=1 that cycle; WAIT begins in cycle N+2.
- **Completion**: done sampled at edge M gives `OUT_finish`=1 in cycle M+1 (DONE). ENTER_A and cleared outputs follow in cycle M+2.
- **Minimum issue-to-finish latency**: 2 cycles.
- **Watchdog**: `OUT_error` occurs in cycle N+2+`TIMEOUT`-1 when no done arrives.
- **Throughput**: `OUT_start` fires at most once per operation; `OUT_finish` and `OUT_error` are never both high.

## Test plan
- **Reset**: assert `IN_rst_n`=0 mid-WAIT → next cycle all outputs 0, `OUT_key_ready`=1, no `OUT_finish`.
- **Basic add**: keys 1,2,A,3,F, done pulsed 3 cycles after start → SRCH:SRCL=0x000C, DSTH:DSTL=0x0003, `OUT_ALU_OP`=0x01, exactly one `OUT_start`, `OUT_finish` 1 cycle after done.
- **Digit limit and operator replace**: keys 9,9,9,9,9,B,C,7,F → src=0x270F (fifth 9 ignored), `OUT_ALU_OP`=0x04 (C replaces B), dst=0x0007.
- **Ignored keys**: F, then A before any digit, then 5,E,F → only 5,E are accepted and no issue occurs. Then 2,F → ALU_OP=0x10, src=5, dst=2, one start.
- **Busy drop**: during WAIT pulse keys 4,F → operands unchanged, no second start; after finish, src/dst are 0 in ENTER_A.
- **Watchdog**: `TIMEOUT`=8, no done → `OUT_error` exactly 8 cycles after `OUT_start`, operands cleared. Done coincident with expiry → `OUT_finish` only.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU sequencer: collects operand A, an operator and operand B from
// decoded key codes, then issues one ALU operation guarded by a watchdog.
module calc_entry_ctrl #(
  parameter int MAX_DIGITS = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       IN_clk,
  input  logic       IN_rst_n,
  input  logic       IN_key_valid,
  input  logic [3:0] IN_key_code,
  input  logic       IN_alu_done,
  output logic       OUT_key_ready,
  output logic [7:0] OUT_SRCH,
  output logic [7:0] OUT_SRCL,
  output logic [7:0] OUT_DSTH,
  output logic [7:0] OUT_DSTL,
  output logic [7:0] OUT_ALU_OP,
  output logic       OUT_start,
  output logic       OUT_finish,
  output logic       OUT_error,
  output logic [2:0] OUT_dbg_state
);

  localparam int CW  = $clog2(MAX_DIGITS + 1);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     acc_a_q, acc_a_d;
  logic [15:0]     acc_b_q, acc_b_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d;
  logic [CW-1:0]   cnt_b_q, cnt_b_d;
  logic [7:0]      op_q, op_d;
  logic [WDW-1:0]  wd_q, wd_d;

  logic        is_digit;
  logic        is_op;
  logic        is_eq;
  logic [7:0]  op_code;
  logic [15:0] digit_ext;
  logic        wd_expired;

  // Valid/ready: a key is consumed only in a cycle where IN_key_valid and
  // OUT_key_ready are both high; keys offered while not ready are dropped.
  assign is_digit   = IN_key_valid && (IN_key_code <= 4'd9);
  assign is_op      = IN_key_valid && (IN_key_code >= 4'hA) && (IN_key_code <= 4'hE);
  assign is_eq      = IN_key_valid && (IN_key_code == 4'hF);
  assign digit_ext  = {12'd0, IN_key_code};
  assign wd_expired = (wd_q == '0);

  always_comb begin
    op_code = 8'h00;
    case (IN_key_code)
      4'hA:    op_code = 8'h01;
      4'hB:    op_code = 8'h02;
      4'hC:    op_code = 8'h04;
      4'hD:    op_code = 8'h08;
      4'hE:    op_code = 8'h10;
      default: op_code = 8'h00;
    endcase
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q <= S_ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ENTER_A: if (is_op && (cnt_a_q != '0)) state_d = S_ENTER_B;
      S_ENTER_B: if (is_eq && (cnt_b_q != '0)) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        // A done arriving in the expiry cycle still counts as success
        if (IN_alu_done)     state_d = S_DONE;
        else if (wd_expired) state_d = S_ENTER_A;
      end
      S_DONE:    state_d = S_ENTER_A;
      default:   state_d = S_ENTER_A;
    endcase
  end

  always_comb begin
    OUT_key_ready = (state_q == S_ENTER_A) || (state_q == S_ENTER_B);
    OUT_start     = (state_q == S_ISSUE);
    OUT_finish    = (state_q == S_DONE);
    OUT_error     = (state_q == S_WAIT) && !IN_alu_done && wd_expired;
    OUT_dbg_state = state_q;
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      op_q    <= '0;
      wd_q    <= '0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    op_d    = op_q;
    wd_d    = wd_q;
    case (state_q)
      S_ENTER_A: begin
        if (is_digit && (cnt_a_q < CW'(MAX_DIGITS))) begin
          acc_a_d = acc_a_q * 16'd10 + digit_ext;
          cnt_a_d = cnt_a_q + CW'(1);
        end
        if (is_op && (cnt_a_q != '0)) op_d = op_code;
      end
      S_ENTER_B: begin
        if (is_digit && (cnt_b_q < CW'(MAX_DIGITS))) begin
          acc_b_d = acc_b_q * 16'd10 + digit_ext;
          cnt_b_d = cnt_b_q + CW'(1);
        end
        // The operator may be changed until operand B has started
        if (is_op && (cnt_b_q == '0)) op_d = op_code;
      end
      S_ISSUE: wd_d = WDW'(TIMEOUT - 1);
      S_WAIT: begin
        if (!IN_alu_done) begin
          if (wd_expired) begin
            acc_a_d = '0;
            acc_b_d = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            op_d    = '0;
          end else begin
            wd_d = wd_q - WDW'(1);
          end
        end
      end
      S_DONE: begin
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        op_d    = '0;
      end
      default: ;
    endcase
  end

  assign OUT_SRCH   = acc_a_q[15:8];
  assign OUT_SRCL   = acc_a_q[7:0];
  assign OUT_DSTH   = acc_b_q[15:8];
  assign OUT_DSTL   = acc_b_q[7:0];
  assign OUT_ALU_OP = op_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key sequences with hand-computed operands,
// timing checks on start/finish/error and a scoreboard of issued operations.
module tb_calc_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       alu_done = 1'b0;
  logic       key_ready;
  logic [7:0] srch, srcl, dsth, dstl, alu_op;
  logic       start, finish, error;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0, n_finish = 0, n_error = 0;
  int st_cyc = 0, fin_cyc = 0;
  logic [39:0] exp_q[$];

  calc_entry_ctrl #(.MAX_DIGITS(4), .TIMEOUT(8)) dut (
    .IN_clk(clk), .IN_rst_n(rst_n), .IN_key_valid(key_valid), .IN_key_code(key_code),
    .IN_alu_done(alu_done), .OUT_key_ready(key_ready), .OUT_SRCH(srch), .OUT_SRCL(srcl),
    .OUT_DSTH(dsth), .OUT_DSTL(dstl), .OUT_ALU_OP(alu_op), .OUT_start(start),
    .OUT_finish(finish), .OUT_error(error), .OUT_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: every start is matched against the next expected operation
  always @(negedge clk) begin
    if (start) begin
      n_start++;
      st_cyc = cyc;
      if (exp_q.size() != 0) check("sb_operands", {srch, srcl, dsth, dstl, alu_op}, exp_q.pop_front());
      else check("sb_start_expected", 40'(exp_q.size()), 40'd1);
    end
    if (finish) begin
      n_finish++;
      fin_cyc = cyc;
    end
    if (error) n_error++;
  end

  // drivers
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'd0;
    #1;
  endtask

  task automatic press_seq(input logic [3:0] ks[], input int n);
    for (int i = 0; i < n; i++) press(ks[i]);
  endtask

  task automatic pulse_done();
    alu_done = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0;
    #1;
  endtask

  task automatic push_exp(input logic [15:0] s, input logic [15:0] d, input logic [7:0] op);
    exp_q.push_back({s, d, op});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 40'(key_ready), 40'd1);
    check({tag, "_ops"}, {srch, srcl, dsth, dstl, alu_op}, 40'd0);
    check({tag, "_flags"}, {37'd0, start, finish, error}, 40'd0);
  endtask

  initial begin : main
    logic [3:0] ks[];
    int snap;
    int k;

    #12;
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // basic add: 12 + 3
    push_exp(16'h000C, 16'h0003, 8'h01);
    ks = '{4'h1, 4'h2, 4'hA, 4'h3, 4'hF};
    press_seq(ks, 5);
    check("add_start", 40'(start), 40'd1);
    tick(); tick(); tick();
    pulse_done();
    check("add_finish", 40'(finish), 40'd1);
    check("add_hold", {srch, srcl, dsth, dstl, alu_op}, {16'h000C, 16'h0003, 8'h01});
    #4;
    check("add_latency", 40'(fin_cyc - st_cyc), 40'd4);
    tick();
    check_idle("add_after");

    // digit limit and operator replacement
    push_exp(16'h270F, 16'h0007, 8'h04);
    ks = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'hB, 4'hC, 4'h7, 4'hF};
    press_seq(ks, 9);
    check("lim_start", 40'(start), 40'd1);
    tick();
    pulse_done();
    check("lim_finish", 40'(finish), 40'd1);
    tick();

    // ignored keys
    snap = n_start;
    ks = '{4'hF, 4'hA, 4'h5, 4'hE, 4'hF};
    press_seq(ks, 5);
    tick();
    check("ign_no_start", 40'(n_start - snap), 40'd0);
    check("ign_state", 40'(dbg_state), 40'd1);
    check("ign_ops", {srch, srcl, dsth, dstl, alu_op}, {16'h0005, 16'h0000, 8'h10});
    push_exp(16'h0005, 16'h0002, 8'h10);
    ks = '{4'h2, 4'hF};
    press_seq(ks, 2);
    check("ign_start", 40'(start), 40'd1);
    tick();
    pulse_done();
    tick();

    // busy drop: keys during WAIT have no effect
    snap = n_start;
    push_exp(16'h0001, 16'h0001, 8'h08);
    ks = '{4'h1, 4'hD, 4'h1, 4'hF};
    press_seq(ks, 4);
    tick();
    ks = '{4'h4, 4'hF};
    press_seq(ks, 2);
    check("busy_ops", {srch, srcl, dsth, dstl, alu_op}, {16'h0001, 16'h0001, 8'h08});
    pulse_done();
    check("busy_finish", 40'(finish), 40'd1);
    tick();
    tick(); tick();
    check("busy_one_start", 40'(n_start - snap), 40'd1);
    check_idle("busy_after");

    // watchdog expiry
    snap = n_finish;
    push_exp(16'h0003, 16'h0004, 8'h08);
    ks = '{4'h3, 4'hD, 4'h4, 4'hF};
    press_seq(ks, 4);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (error) begin k = i; break; end
    end
    check("wd_error_delay", 40'(k), 40'd8);
    tick();
    check_idle("wd_after");
    check("wd_no_finish", 40'(n_finish - snap), 40'd0);

    // done coincident with expiry
    push_exp(16'h0006, 16'h0001, 8'h01);
    ks = '{4'h6, 4'hA, 4'h1, 4'hF};
    press_seq(ks, 4);
    for (int i = 0; i < 8; i++) tick();
    alu_done = 1'b1;
    #1;
    check("coin_no_error", 40'(error), 40'd0);
    @(posedge clk); #1;
    alu_done = 1'b0;
    #1;
    check("coin_finish", 40'(finish), 40'd1);
    tick();
    check_idle("coin_after");

    // reset in the middle of WAIT
    push_exp(16'h0008, 16'h0002, 8'h02);
    ks = '{4'h8, 4'hB, 4'h2, 4'hF};
    press_seq(ks, 4);
    tick(); tick();
    check("rst_in_wait", 40'(dbg_state), 40'd3);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    tick();
    rst_n = 1'b1;
    snap = n_finish;
    pulse_done();
    tick();
    check("rst_done_ignored", 40'(n_finish - snap), 40'd0);
    check_idle("rst_after");

    check("total_starts", 40'(n_start), 40'd7);
    check("total_finish", 40'(n_finish), 40'd5);
    check("total_errors", 40'(n_error), 40'd1);
    check("sb_drained", 40'(exp_q.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

endmodule
